med_ctrl: RTL and testbench

MED_CTRL -- requirements
Module: med_ctrl

---
 rtl/med_ctrl.sv | 113 +++++++++++
 tb/tb_med_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/med_ctrl.sv
// med_ctrl: fill/run/flush controller feeding a 5-tap median delay line.
// Define MED_CTRL_FLUSH_EN to pad the frame tail with two repeats of the last sample.
module med_ctrl #(
    parameter int N    = 4,
    parameter int TAPS = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         shift_en,
    output logic [N-1:0] shift_data,
    output logic         win_valid,
    input  logic         win_ready,
    output logic         win_last,
    output logic [2:0]   fill_cnt,
    output logic         err_short
);
    localparam logic [2:0] FULL = 3'(TAPS);
`ifdef MED_CTRL_FLUSH_EN
    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
    logic [N-1:0] pad_q, pad_d;
    logic         pad_cnt_q, pad_cnt_d;
`else
    typedef enum logic [1:0] {FILL, RUN} state_t;
`endif
    state_t     state_q, state_d;
    logic [2:0] fill_cnt_q, fill_cnt_d;
    logic       win_valid_q, win_valid_d, win_last_q, win_last_d, err_short_q, err_short_d;
    logic       gate, accept, set, last;
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        err_short_d = 1'b0;
        set         = 1'b0;
        last        = 1'b0;
        gate        = !win_valid_q | win_ready;
        in_ready    = !rst && (state_q == FILL || (state_q == RUN && gate));
        accept      = in_valid & in_ready;
        shift_en    = accept;
        shift_data  = in_data;
`ifdef MED_CTRL_FLUSH_EN
        pad_d       = pad_q;
        pad_cnt_d   = pad_cnt_q;
        if (state_q == FLUSH) begin
            shift_en   = !rst && gate;
            shift_data = pad_q;
        end
`endif
        if (accept) begin
            if (in_last && fill_cnt_q < FULL - 3'd1) begin
                fill_cnt_d  = 3'd0;
                err_short_d = 1'b1;
            end else begin
                fill_cnt_d = (fill_cnt_q == FULL) ? FULL : fill_cnt_q + 3'd1;
                set        = fill_cnt_q >= FULL - 3'd1;
                state_d    = (fill_cnt_q == FULL - 3'd1) ? RUN : state_q;
                if (in_last) begin
`ifdef MED_CTRL_FLUSH_EN
                    state_d   = FLUSH;
                    pad_d     = in_data;
                    pad_cnt_d = 1'b0;
`else
                    last       = 1'b1;
                    state_d    = FILL;
                    fill_cnt_d = 3'd0;
`endif
                end
            end
        end
`ifdef MED_CTRL_FLUSH_EN
        // second pad shift closes the frame
        if (state_q == FLUSH && shift_en) begin
            set       = 1'b1;
            last      = pad_cnt_q;
            pad_cnt_d = !pad_cnt_q;
            state_d    = pad_cnt_q ? FILL : state_q;
            fill_cnt_d = pad_cnt_q ? 3'd0 : fill_cnt_q;
        end
`endif
        win_valid_d = set | (win_valid_q & !win_ready);
        win_last_d  = set ? last : (win_last_q & !win_ready);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            fill_cnt_q  <= 3'd0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            err_short_q <= 1'b0;
`ifdef MED_CTRL_FLUSH_EN
            pad_q       <= '0;
            pad_cnt_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            err_short_q <= err_short_d;
`ifdef MED_CTRL_FLUSH_EN
            pad_q       <= pad_d;
            pad_cnt_q   <= pad_cnt_d;
`endif
        end
    end
    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;
    assign fill_cnt  = fill_cnt_q;
    assign err_short = err_short_q;
endmodule

// File: tb/tb_med_ctrl.sv
// tb_med_ctrl: frame-position reference model, directed frames plus random traffic.
module tb_med_ctrl;
    localparam int N = 4;
`ifdef MED_CTRL_FLUSH_EN
    localparam int FLUSH = 1;
`else
    localparam int FLUSH = 0;
`endif
    logic clk = 0, rst = 0, in_valid = 0, in_last = 0, win_ready = 0;
    logic [N-1:0] in_data = '0;
    logic in_ready, shift_en, win_valid, win_last, err_short;
    logic [N-1:0] shift_data;
    logic [2:0] fill_cnt;
    int checks = 0, errors = 0, wins = 0, lasts = 0;
    int pos, pads, m_pad;
    bit m_wv, m_wl, m_err;

    med_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .shift_en(shift_en), .shift_data(shift_data),
        .win_valid(win_valid), .win_ready(win_ready), .win_last(win_last),
        .fill_cnt(fill_cnt), .err_short(err_short)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pos = 0; pads = 0; m_pad = 0; m_wv = 0; m_wl = 0; m_err = 0;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input bit v, input int d, input bit l, input bit r);
        bit ir, acc, psh, ev, lst, se;
        int npos, npads, npad, sd;
        in_valid = v; in_data = N'(d); in_last = l; win_ready = r;
        #1;
        ir  = pads == 0 && (pos < 5 || !m_wv || r);
        acc = v && ir;
        psh = pads > 0 && (!m_wv || r);
        se  = acc || psh;
        sd  = pads > 0 ? m_pad : d;
        chk("in_ready", in_ready, ir);
        chk("shift_en", shift_en, se);
        if (se) chk("shift_data", shift_data, sd);
        chk("win_valid", win_valid, m_wv);
        chk("win_last", win_valid ? win_last : 0, m_wv ? m_wl : 0);
        chk("fill_cnt", fill_cnt, pads > 0 ? 5 : pos);
        chk("err_short", err_short, m_err);
        if (win_valid && r) begin
            wins++;
            if (win_last) lasts++;
        end
        ev = 0; lst = 0; npos = pos; npads = pads; npad = m_pad;
        if (acc) begin
            if (l && pos + 1 < 5) npos = 0;
            else begin
                ev = pos + 1 >= 5;
                npos = pos + 1 > 5 ? 5 : pos + 1;
                if (l) begin
                    if (FLUSH != 0) begin npads = 2; npad = d; end
                    else begin lst = 1; npos = 0; end
                end
            end
        end
        if (psh) begin
            ev = 1; lst = pads == 1; npads = pads - 1;
            if (npads == 0) npos = 0;
        end
        @(posedge clk);
        m_err = acc && l && pos + 1 < 5;
        m_wl = ev ? lst : (m_wl && !(m_wv && r));
        m_wv = ev || (m_wv && !r);
        pos = npos; pads = npads; m_pad = npad;
        @(negedge clk);
    endtask

    // Asserted mid-cycle so the asynchronous clear is observable before any edge.
    task automatic do_reset();
        in_valid = 1; in_last = 0;
        #2 rst = 1;
        #1;
        chk("rst_shift_en", shift_en, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_win_last", win_last, 0);
        chk("rst_fill_cnt", fill_cnt, 0);
        chk("rst_err_short", err_short, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0; in_valid = 0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        for (int i = 1; i <= 5; i++) cycle(1, i, 0, 1);
        chk("lit_first_window", win_valid, 1);
        chk("lit_fill_full", fill_cnt, 5);
        for (int i = 0; i < 4; i++) cycle(1, 6, 0, 0);
        chk("lit_window_held", win_valid, 1);
        for (int i = 0; i < 3; i++) cycle(1, 7 + i, 0, 1);
        do_reset();
        cycle(1, 3, 0, 1); cycle(1, 9, 0, 1); cycle(1, 1, 1, 1);
        chk("lit_err_pulse", err_short, 1);
        chk("lit_err_fill", fill_cnt, 0);
        chk("lit_err_nowin", win_valid, 0);
        cycle(0, 0, 0, 1);
        chk("lit_err_once", err_short, 0);
        wins = 0; lasts = 0;
        for (int i = 1; i <= 7; i++) cycle(1, i, i == 7, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
        chk("lit_frame_windows", wins, FLUSH != 0 ? 5 : 3);
        chk("lit_frame_lasts", lasts, 1);
        chk("lit_frame_fill", fill_cnt, 0);
        chk("lit_frame_ready", in_ready, 1);
        for (int i = 1; i <= 5; i++) cycle(1, i, 0, 0);
        do_reset();
        chk("lit_after_rst_nowin", win_valid, 0);
        for (int i = 0; i < 4000; i++) begin
            if (i % 700 == 699) do_reset();
            else cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                       $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
